// File: rtl/mul_iter_unit.sv
// ============================================================================
// Module   : mul_iter_unit (with helper cores vedic_mul_2x2, vedic_mul_4x4)
// Purpose  : Iterative RV32M multiplier for the EX stage. It handles MUL,
//            MULH, MULHSU and MULHU. Each CALC cycle, the |rs1| magnitude is
//            multiplied by one 4-bit nibble of |rs2|. This uses eight 4x4
//            vedic cores, and the shifted partial product is added into a
//            64-bit accumulator. A final SIGN cycle applies the result sign.
//            A DONE cycle then strobes the selected half with its rd tag.
// Ports    : clk_i    - clock, rising edge
//            rst_i    - asynchronous active-high reset
//            start_i  - multiply request, sampled only in IDLE
//            op_i     - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//            rs1_i    - multiplicand
//            rs2_i    - multiplier
//            rd_i     - destination tag
//            flush_i  - abort the operation in flight
//            busy_o   - high whenever not IDLE
//            valid_o  - one-cycle result strobe
//            result_o - selected product half
//            rd_o     - tag of the result on result_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// 2x2 vedic (urdhva) multiplier.
module vedic_mul_2x2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  logic t0, t1, c1, hh;
  assign t0 = a_i[1] & b_i[0];
  assign t1 = a_i[0] & b_i[1];
  assign c1 = t0 & t1;
  assign hh = a_i[1] & b_i[1];
  assign p_o = {hh & c1, hh ^ c1, t0 ^ t1, a_i[0] & b_i[0]};
endmodule

// 4x4 vedic multiplier built from four 2x2 cores.
module vedic_mul_4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [3:0] ll, lh, hl, hh;
  logic [4:0] mid;

  vedic_mul_2x2 u_ll (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(ll));
  vedic_mul_2x2 u_lh (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(lh));
  vedic_mul_2x2 u_hl (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(hl));
  vedic_mul_2x2 u_hh (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(hh));

  assign mid = {1'b0, lh} + {1'b0, hl};
  assign p_o = {4'b0000, ll} + {1'b0, mid, 2'b00} + {hh, 4'b0000};
endmodule

module mul_iter_unit #(
  parameter int XLEN = 32,
  parameter int NIB  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o
);
  localparam int NNIB = XLEN / NIB;
  localparam int CW   = $clog2(NNIB);
  localparam int PPW  = XLEN + NIB;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_MULU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [1:0]          op_q, op_d;
  logic [4:0]          tag_q, tag_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_q, rd_d;

  logic [4:0]          bit_base;
  logic [NIB-1:0]      b_nib;
  logic [2*NIB-1:0]    prod [NNIB];
  logic [PPW-1:0]      pp;
  logic [2*XLEN-1:0]   acc_sum, acc_signed;
  logic                s1, s2;
  logic [XLEN-1:0]     rs1_abs, rs2_abs;

  // Bit offset of the current rs2 nibble; also the partial product shift.
  assign bit_base = {cnt_q, 2'b00};
  assign b_nib    = b_q[bit_base +: NIB];

  generate
    for (genvar k = 0; k < NNIB; k++) begin : g_nib
      vedic_mul_4x4 u_vm (
        .a_i (a_q[k*NIB +: NIB]),
        .b_i (b_nib),
        .p_o (prod[k])
      );
    end
  endgenerate

  always_comb begin
    pp = '0;
    for (int k = 0; k < NNIB; k++) begin
      pp = pp + ({{(PPW-2*NIB){1'b0}}, prod[k]} << (NIB*k));
    end
  end

  assign acc_sum    = acc_q + ({{(XLEN-NIB){1'b0}}, pp} << bit_base);
  assign acc_signed = neg_q ? (~acc_q + 64'd1) : acc_q;

  // rs1 is signed except for MULHU; rs2 is signed only for MUL/MULH.
  assign s1      = (op_i != OP_MULU) & rs1_i[XLEN-1];
  assign s2      = ((op_i == OP_MUL) | (op_i == OP_MULH)) & rs2_i[XLEN-1];
  assign rs1_abs = s1 ? (~rs1_i + 32'd1) : rs1_i;
  assign rs2_abs = s2 ? (~rs2_i + 32'd1) : rs2_i;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    tag_d    = tag_q;
    result_d = result_q;
    rd_d     = rd_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          a_d     = rs1_abs;
          b_d     = rs2_abs;
          neg_d   = s1 ^ s2;
          op_d    = op_i;
          tag_d   = rd_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(NNIB-1)) begin
            state_d = S_SIGN;
          end
        end
      end
      S_SIGN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_signed;
          // Output registers load here so result_o is stable during DONE.
          result_d = (op_q == OP_MUL) ? acc_signed[XLEN-1:0]
                                      : acc_signed[2*XLEN-1:XLEN];
          rd_d     = tag_q;
          state_d  = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= '0;
      tag_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  // A flush landing on the DONE cycle kills the strobe.
  assign valid_o  = (state_q == S_DONE) & ~flush_i;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_iter_unit.sv
// ============================================================================
// Module   : tb_mul_iter_unit
// Purpose  : Directed self-checking bench for mul_iter_unit.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_iter_unit;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int nchk = 0;
  int nerr = 0;

  mul_iter_unit dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Issue one op (start high for one cycle N) and wait for valid_o.
  // lat is the cycle offset from N at which valid_o appeared (-1 = none).
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       output logic [31:0] res, output logic [4:0] rdo,
                       output int lat, output int busy_n);
    @(posedge clk_i); #1;
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lat = -1; busy_n = 0; res = '0; rdo = '0;
    for (int k = 1; k <= 20; k++) begin
      if (busy_o) busy_n++;
      if (valid_o) begin
        lat = k; res = result_o; rdo = rd_o;
        break;
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    nchk++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    nchk++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    nchk++; if (result_o !== 32'h0) begin nerr++; $display("FAIL reset_result: got %h expected 0", result_o); end
    nchk++; if (rd_o !== 5'h0) begin nerr++; $display("FAIL reset_rd: got %h expected 0", rd_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_mul_basic();
    logic [31:0] res; logic [4:0] rdo; int lat, bn;
    do_op(2'b00, 32'd7, 32'd6, 5'd5, res, rdo, lat, bn);
    nchk++; if (lat != 10) begin nerr++; $display("FAIL mul_latency: got %0d expected 10", lat); end
    nchk++; if (res !== 32'h0000002A) begin nerr++; $display("FAIL mul_7x6: got %h expected 0000002a", res); end
    nchk++; if (rdo !== 5'd5) begin nerr++; $display("FAIL mul_rd: got %0d expected 5", rdo); end
    nchk++; if (bn != 10) begin nerr++; $display("FAIL mul_busy_cycles: got %0d expected 10", bn); end
    @(posedge clk_i); #1;
    nchk++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      nerr++; $display("FAIL mul_after_done: got busy=%b valid=%b expected 0 0", busy_o, valid_o);
    end
  endtask

  task automatic test_signed_ops();
    logic [1:0]  ops [7] = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00};
    logic [31:0] av  [7] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv  [7] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h00000002, 32'h00000002};
    logic [31:0] ev  [7] = '{32'h40000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000001,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] res; logic [4:0] rdo; int lat, bn;
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], av[i], bv[i], 5'(i + 10), res, rdo, lat, bn);
      nchk++; if (lat != 10 || res !== ev[i] || rdo !== 5'(i + 10)) begin
        nerr++;
        $display("FAIL signed_vec%0d: got lat=%0d res=%h rd=%0d expected lat=10 res=%h rd=%0d",
                 i, lat, res, rdo, ev[i], i + 10);
      end
    end
  endtask

  // start_i held high; operands change every cycle, only IDLE-cycle ones count.
  task automatic test_back_to_back();
    int vcount = 0;
    @(posedge clk_i); #1;
    for (int c = 0; c <= 21; c++) begin
      start_i = 1'b1; op_i = 2'b00; rd_i = 5'(c);
      if (c == 0)       begin rs1_i = 32'd3; rs2_i = 32'd4; end
      else if (c == 11) begin rs1_i = 32'd5; rs2_i = 32'd7; end
      else              begin rs1_i = 32'(c * 1000 + 1); rs2_i = 32'd99; end
      if (valid_o) begin
        vcount++;
        nchk++;
        if (c == 10) begin
          if (result_o !== 32'd12 || rd_o !== 5'd0) begin
            nerr++; $display("FAIL b2b_first: got %h rd=%0d expected 0000000c rd=0", result_o, rd_o);
          end
        end else if (c == 21) begin
          if (result_o !== 32'd35 || rd_o !== 5'd11) begin
            nerr++; $display("FAIL b2b_second: got %h rd=%0d expected 00000023 rd=11", result_o, rd_o);
          end
        end else begin
          nerr++; $display("FAIL b2b_spurious_valid: got valid at cycle %0d expected 10 or 21", c);
        end
      end
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    nchk++; if (vcount != 2) begin nerr++; $display("FAIL b2b_count: got %0d expected 2", vcount); end
  endtask

  task automatic test_flush();
    int vcount = 0;
    @(posedge clk_i); #1;
    for (int c = 0; c <= 16; c++) begin
      start_i = (c == 0) || (c == 5);
      flush_i = (c == 4);
      op_i = 2'b00;
      if (c == 0) begin rs1_i = 32'd9; rs2_i = 32'd9; rd_i = 5'd3; end
      if (c == 5) begin rs1_i = 32'd3; rs2_i = 32'd5; rd_i = 5'd7; end
      if (c == 5) begin
        nchk++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL flush_idle: got busy=%b expected 0", busy_o); end
      end
      if (valid_o) begin
        vcount++;
        if (c == 15) begin
          nchk++; if (result_o !== 32'h0000000F || rd_o !== 5'd7) begin
            nerr++; $display("FAIL flush_restart: got %h rd=%0d expected 0000000f rd=7", result_o, rd_o);
          end
        end
      end
      @(posedge clk_i); #1;
    end
    start_i = 1'b0; flush_i = 1'b0;
    nchk++; if (vcount != 1) begin nerr++; $display("FAIL flush_valid_count: got %0d expected 1", vcount); end

    // Flush coinciding with DONE: strobe suppressed, back to IDLE.
    start_i = 1'b1; rs1_i = 32'd2; rs2_i = 32'd2; rd_i = 5'd1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    #1;
    nchk++; if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
      nerr++; $display("FAIL flush_done: got valid=%b busy=%b expected 0 1", valid_o, busy_o);
    end
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    nchk++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL flush_done_idle: got busy=%b expected 0", busy_o); end

    // Start and flush together in IDLE: start dropped.
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; flush_i = 1'b0;
    nchk++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL flush_start_drop: got busy=%b expected 0", busy_o); end
  endtask

  task automatic test_reset_mid();
    int vcount = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; op_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd9; rd_i = 5'd4;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    nchk++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'h0 || rd_o !== 5'h0) begin
      nerr++; $display("FAIL reset_mid: got busy=%b valid=%b res=%h rd=%0d expected 0 0 0 0",
                       busy_o, valid_o, result_o, rd_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (valid_o || busy_o) vcount++;
      @(posedge clk_i); #1;
    end
    nchk++; if (vcount != 0) begin nerr++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", vcount); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_signed_ops();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
